// File: rtl/alu_ctrl_pkg.sv
// Shared types for the ALU request controller: opcodes, ALU select encoding,
// FSM states, status bit positions and the opcode-to-control decode.
package alu_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHR = 3'd5,
    OP_SHL = 3'd6,
    OP_NOR = 3'd7
  } op_e;

  // Result-mux codes, placed in alu_sel[4:2]
  localparam logic [2:0] SEL_OR  = 3'b001;
  localparam logic [2:0] SEL_AND = 3'b010;
  localparam logic [2:0] SEL_XOR = 3'b011;
  localparam logic [2:0] SEL_ADD = 3'b100;
  localparam logic [2:0] SEL_SHR = 3'b101;
  localparam logic [2:0] SEL_SHL = 3'b110;

  // Operand inversion controls, alu_sel[1:0] = {invert B, invert A}
  localparam logic [1:0] INV_NONE = 2'b00;
  localparam logic [1:0] INV_B    = 2'b10;
  localparam logic [1:0] INV_AB   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int STAT_C = 0;
  localparam int STAT_Z = 1;
  localparam int STAT_O = 2;
  localparam int STAT_N = 3;

  typedef struct packed {
    logic [4:0] sel;
    logic       cin;
  } alu_ctrl_t;

  // SUB is A + ~B + 1; NOR is ~A & ~B through the AND mux
  function automatic alu_ctrl_t decode_op(input op_e op);
    alu_ctrl_t c;
    c.sel = '0;
    c.cin = 1'b0;
    case (op)
      OP_ADD: c.sel = {SEL_ADD, INV_NONE};
      OP_SUB: begin
        c.sel = {SEL_ADD, INV_B};
        c.cin = 1'b1;
      end
      OP_AND: c.sel = {SEL_AND, INV_NONE};
      OP_OR:  c.sel = {SEL_OR,  INV_NONE};
      OP_XOR: c.sel = {SEL_XOR, INV_NONE};
      OP_SHR: c.sel = {SEL_SHR, INV_NONE};
      OP_SHL: c.sel = {SEL_SHL, INV_NONE};
      OP_NOR: c.sel = {SEL_AND, INV_AB};
      default: c.sel = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant with a 1-bit priority pointer; purely combinational.
// The pointer moves to the non-granted requester only when i_adv is high and a grant is made.
module rr_arbiter2 (
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  input  logic       i_adv,
  output logic [1:0] o_gnt,
  output logic       o_ptr
);

  always_comb begin
    o_gnt = i_req;
    if (&i_req) begin
      o_gnt = i_ptr ? 2'b10 : 2'b01;
    end
    o_ptr = i_ptr;
    if (i_adv && (|o_gnt)) begin
      o_ptr = o_gnt[0];
    end
  end

endmodule

// File: rtl/alu_req_ctrl.sv
// Arbitrates two requesters onto the shared ALU: accept in T, drive ALU in T+1, response in T+2.
// Response is held in RESP until rsp_ready; no new request is accepted until it drains.
module alu_req_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [2:0]       req0_op,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [4:0]       alu_sel,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_cout,
  input  logic [3:0]       alu_status,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_cout,
  output logic [3:0]       rsp_status,
  output logic             busy
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_ptr;
  logic             w_ptr_nxt;
  logic             w_idle;
  logic             w_take;
  logic [1:0]       w_req;
  logic [1:0]       w_gnt;
  logic [2:0]       w_op_in;
  logic [WIDTH-1:0] w_a_in;
  logic [WIDTH-1:0] w_b_in;
  op_e              r_op;
  logic             r_id;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  alu_ctrl_t        w_ctrl;
  logic [3:0]       w_status;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_cout;
  logic [3:0]       r_rsp_status;

  assign w_req  = {req1_valid, req0_valid};
  assign w_idle = (r_state == ST_IDLE);
  assign w_take = w_idle & (|w_req);

  rr_arbiter2 u_arb (
    .i_req (w_req),
    .i_ptr (r_ptr),
    .i_adv (w_idle),
    .o_gnt (w_gnt),
    .o_ptr (w_ptr_nxt)
  );

  assign req0_ready = w_idle & w_gnt[0];
  assign req1_ready = w_idle & w_gnt[1];

  assign w_op_in = w_gnt[1] ? req1_op : req0_op;
  assign w_a_in  = w_gnt[1] ? req1_a  : req0_a;
  assign w_b_in  = w_gnt[1] ? req1_b  : req0_b;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (|w_req) w_state_nxt = ST_EXEC;
      ST_EXEC: w_state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Operands are loaded on grant and then simply held until the next grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op    <= OP_ADD;
      r_id    <= 1'b0;
      r_alu_a <= '0;
      r_alu_b <= '0;
    end else if (w_take) begin
      r_op    <= op_e'(w_op_in);
      r_id    <= w_gnt[1];
      r_alu_a <= w_a_in;
      r_alu_b <= w_b_in;
    end
  end

  assign w_ctrl   = decode_op(r_op);
  assign alu_a    = r_alu_a;
  assign alu_b    = r_alu_b;
  assign alu_sel  = (r_state == ST_EXEC) ? w_ctrl.sel : 5'b00000;
  assign alu_cin  = (r_state == ST_EXEC) ? w_ctrl.cin : 1'b0;

  assign w_status = {alu_status[STAT_N], alu_status[STAT_O],
                     alu_status[STAT_Z], alu_status[STAT_C]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_id     <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_cout   <= 1'b0;
      r_rsp_status <= 4'b0000;
    end else if (r_state == ST_EXEC) begin
      r_rsp_id     <= r_id;
      r_rsp_data   <= alu_out;
      r_rsp_cout   <= alu_cout;
      r_rsp_status <= w_status;
    end
  end

  assign rsp_valid  = (r_state == ST_RESP);
  assign rsp_id     = r_rsp_id;
  assign rsp_data   = r_rsp_data;
  assign rsp_cout   = r_rsp_cout;
  assign rsp_status = r_rsp_status;
  assign busy       = ~w_idle;

endmodule

// File: tb/tb_alu_req_ctrl.sv
// Bench for alu_req_ctrl: behavioural ALU, per-requester expected queues and a negedge monitor.
module tb_alu_req_ctrl;

  localparam int W = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]   req_valid = 2'b00;
  logic [2:0]   req_op [2];
  logic [W-1:0] req_a  [2];
  logic [W-1:0] req_b  [2];
  logic         req0_ready, req1_ready;
  logic [W-1:0] alu_a, alu_b, alu_out, rsp_data;
  logic [4:0]   alu_sel;
  logic         alu_cin, alu_cout, rsp_valid, rsp_id, rsp_cout, busy;
  logic [3:0]   alu_status, rsp_status;
  logic         rsp_ready = 1'b1;

  alu_req_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req_valid[0]), .req1_valid(req_valid[1]),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_op(req_op[0]), .req1_op(req_op[1]),
    .req0_a(req_a[0]), .req0_b(req_b[0]), .req1_a(req_a[1]), .req1_b(req_b[1]),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_cout(alu_cout), .alu_status(alu_status),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_cout(rsp_cout), .rsp_status(rsp_status), .busy(busy)
  );

  // External ALU: operand inversion, carry-in, result mux selected by alu_sel
  logic [W-1:0] ea, eb;
  logic [W:0]   sum;
  logic         ovf;
  always_comb begin
    ea = alu_sel[0] ? ~alu_a : alu_a;
    eb = alu_sel[1] ? ~alu_b : alu_b;
    sum = {1'b0, ea} + {1'b0, eb} + {{W{1'b0}}, alu_cin};
    alu_out = '0;
    alu_cout = 1'b0;
    ovf = 1'b0;
    case (alu_sel[4:2])
      3'b001: alu_out = ea | eb;
      3'b010: alu_out = ea & eb;
      3'b011: alu_out = ea ^ eb;
      3'b100: begin
        alu_out = sum[W-1:0];
        alu_cout = sum[W];
        ovf = (ea[W-1] == eb[W-1]) && (sum[W-1] != ea[W-1]);
      end
      3'b101: alu_out = ea >> eb[5:0];
      3'b110: alu_out = ea << eb[5:0];
      default: alu_out = '0;
    endcase
    alu_status = {alu_out[W-1], ovf, (alu_out == '0), alu_cout};
  end

  typedef struct packed {
    logic [4:0]   sel;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] data;
    logic         cout;
    logic [3:0]   status;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   rsp_count = 0;
  int   obs_ids[$];
  logic [3:0] last_status = 4'b0;
  logic [1:0] acc_seen = 2'b00;
  int   m_phase = 0;
  logic m_ptr = 1'b0;
  exp_t cur;
  logic cur_id = 1'b0;
  int   rdy_mode = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Reference behaviour from opcode semantics, independent of the select encoding
  function automatic exp_t ref_txn(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [4:0] sel_tab [8];
    logic signed [W:0] s;
    logic [W:0] u;
    logic o;
    sel_tab = '{5'b10000, 5'b10010, 5'b01000, 5'b00100, 5'b01100, 5'b10100, 5'b11000, 5'b01011};
    e.sel = sel_tab[op];
    e.cin = (op == 3'd1);
    e.a = a;
    e.b = b;
    e.cout = 1'b0;
    o = 1'b0;
    case (op)
      3'd0: begin
        u = {1'b0, a} + {1'b0, b};
        e.data = u[W-1:0];
        e.cout = u[W];
        s = $signed({a[W-1], a}) + $signed({b[W-1], b});
        o = (s[W] != s[W-1]);
      end
      3'd1: begin
        e.data = a - b;
        e.cout = (a >= b);
        s = $signed({a[W-1], a}) - $signed({b[W-1], b});
        o = (s[W] != s[W-1]);
      end
      3'd2: e.data = a & b;
      3'd3: e.data = a | b;
      3'd4: e.data = a ^ b;
      3'd5: e.data = a >> b[5:0];
      3'd6: e.data = a << b[5:0];
      default: e.data = ~(a | b);
    endcase
    e.status = {e.data[W-1], o, (e.data == '0), e.cout};
    return e;
  endfunction

  // Monitor: models grant order, T+1 ALU drive, T+2 response and its hold under backpressure
  initial begin
    logic [1:0] g_exp;
    logic gi;
    forever begin
      @(negedge clk);
      acc_seen = {req_valid[1] & req1_ready, req_valid[0] & req0_ready};
      chk("rdy_onehot", {127'b0, req0_ready & req1_ready}, 128'b0);
      if (rst) begin
        m_phase = 0;
        m_ptr = 1'b0;
        chk("rst_outs", {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_cout,
                         rsp_status, alu_sel, alu_cin, busy}, 128'b0);
        chk("rst_alu_ab", {alu_a, alu_b}, 128'b0);
      end else begin
        case (m_phase)
          0: begin
            if (req_valid == 2'b11) g_exp = m_ptr ? 2'b10 : 2'b01;
            else g_exp = req_valid;
            chk("grant", {req1_ready, req0_ready}, g_exp);
            chk("idle_outs", {busy, alu_sel, alu_cin, rsp_valid}, 128'b0);
            if (g_exp != 2'b00) begin
              gi = g_exp[1];
              if ((gi ? exp_q1.size() : exp_q0.size()) == 0) begin
                timeout_fail("grant_noexp");
              end else begin
                cur = gi ? exp_q1.pop_front() : exp_q0.pop_front();
                cur_id = gi;
                m_ptr = ~gi;
                m_phase = 1;
              end
            end
          end
          1: begin
            chk("exec_ctl", {alu_sel, alu_cin}, {cur.sel, cur.cin});
            chk("exec_ops", {alu_a, alu_b}, {cur.a, cur.b});
            chk("exec_flags", {busy, rsp_valid, req0_ready, req1_ready}, 4'b1000);
            m_phase = 2;
          end
          default: begin
            chk("resp_flags", {busy, rsp_valid, req0_ready, req1_ready, alu_sel, alu_cin},
                {4'b1100, 6'b000000});
            chk("resp_dat", {rsp_id, rsp_data, rsp_cout, rsp_status},
                {cur_id, cur.data, cur.cout, cur.status});
            if (rsp_ready) begin
              rsp_count++;
              obs_ids.push_back(int'(rsp_id));
              last_status = rsp_status;
              m_phase = 0;
            end
          end
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int r = 0; r < 2; r++) if (acc_seen[r]) req_valid[r] = 1'b0;
    case (rdy_mode)
      0: rsp_ready = 1'b1;
      1: rsp_ready = ($urandom_range(9, 0) < 7);
      default: rsp_ready = 1'b0;
    endcase
  endtask

  task automatic send(input int r, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    while (req_valid[r] && n < 200) begin
      tick();
      n++;
    end
    if (req_valid[r]) timeout_fail("send_wait");
    req_op[r] = op;
    req_a[r] = a;
    req_b[r] = b;
    req_valid[r] = 1'b1;
    if (r == 0) exp_q0.push_back(ref_txn(op, a, b));
    else exp_q1.push_back(ref_txn(op, a, b));
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((req_valid != 2'b00 || m_phase != 0) && n < 500) begin
      tick();
      n++;
    end
    if (req_valid != 2'b00 || m_phase != 0) timeout_fail("wait_idle");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 2'b00;
    exp_q0.delete();
    exp_q1.delete();
    repeat (3) tick();
    rst = 1'b0;
  endtask

  function automatic logic [W-1:0] rand_opnd();
    case ($urandom_range(5, 0))
      0: return '0;
      1: return '1;
      2: return {1'b1, {(W-1){1'b0}}};
      3: return {{(W-8){1'b0}}, 8'($urandom)};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    int ibase;
    int issued [2];
    int ids_exp [4];
    ids_exp = '{0, 1, 0, 1};
    for (int r = 0; r < 2; r++) begin
      req_op[r] = 3'd0;
      req_a[r] = '0;
      req_b[r] = '0;
    end
    repeat (3) tick();
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_busy", {127'b0, busy}, 128'b0);
      chk("idle_regs", {rsp_valid, rsp_data, alu_sel, alu_a}, 128'b0);
    end

    // Contention: both requesters continuously valid
    ibase = obs_ids.size();
    issued = '{0, 0};
    n = 0;
    while (obs_ids.size() < ibase + 4 && n < 100) begin
      for (int r = 0; r < 2; r++) begin
        if (!req_valid[r] && issued[r] < 2) begin
          send(r, 3'd0, (r == 0) ? 64'd1 : 64'd2, {$urandom, $urandom});
          issued[r]++;
        end
      end
      tick();
      n++;
    end
    if (obs_ids.size() < ibase + 4) timeout_fail("contention");
    else for (int k = 0; k < 4; k++) chk("rr_order", 128'(obs_ids[ibase + k]), 128'(ids_exp[k]));
    wait_idle();

    // SUB 5 - 3
    send(0, 3'd1, 64'd5, 64'd3);
    wait_idle();
    chk("sub_NZ", {126'b0, last_status[3], last_status[1]}, 128'b0);
    chk("sub_id", 128'(obs_ids[obs_ids.size() - 1]), 128'd0);

    // Backpressure: hold rsp_ready low for 20 RESP cycles
    rdy_mode = 2;
    rsp_ready = 1'b0;
    send(0, 3'd4, {$urandom, $urandom}, {$urandom, $urandom});
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    if (!rsp_valid) timeout_fail("bp_rsp");
    base = rsp_count;
    send(1, 3'd0, 64'd11, 64'd22);
    repeat (20) begin
      tick();
      chk("bp_rdy", {126'b0, req0_ready, req1_ready}, 128'b0);
    end
    chk("bp_hold_cnt", 128'(rsp_count), 128'(base));
    rdy_mode = 0;
    rsp_ready = 1'b1;
    tick();
    chk("bp_release", 128'(rsp_count), 128'(base + 1));
    wait_idle();

    // Decode sweep
    for (int op = 0; op < 8; op++) begin
      send(op % 2, 3'(op), 64'hF0F0_F0F0_F0F0_F0F0, 64'd4);
      wait_idle();
    end

    // Reset while in EXEC
    send(0, 3'd0, 64'd7, 64'd9);
    n = 0;
    while (n < 20) begin
      tick();
      n++;
      if (acc_seen[0]) break;
    end
    if (!acc_seen[0]) timeout_fail("rstmid_acc");
    base = rsp_count;
    rst = 1'b1;
    req_valid = 2'b00;
    exp_q0.delete();
    exp_q1.delete();
    #1;
    chk("rstmid_outs", {rsp_valid, alu_sel, alu_cin, busy, alu_a}, 128'b0);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rstmid_norsp", 128'(rsp_count), 128'(base));
    ibase = obs_ids.size();
    send(0, 3'd3, 64'd1, 64'd2);
    send(1, 3'd3, 64'd4, 64'd8);
    wait_idle();
    if (obs_ids.size() < ibase + 2) timeout_fail("rstmid_ids");
    else chk("rstmid_first", 128'(obs_ids[ibase]), 128'd0);

    // Random traffic with withdrawals and random backpressure
    rdy_mode = 1;
    for (int c = 0; c < 600; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (!req_valid[r]) begin
          if ($urandom_range(2, 0) == 0) send(r, 3'($urandom_range(7, 0)), rand_opnd(), rand_opnd());
        end else if ($urandom_range(15, 0) == 0) begin
          req_valid[r] = 1'b0;
          if (r == 0) void'(exp_q0.pop_back());
          else void'(exp_q1.pop_back());
        end
      end
      tick();
    end
    rdy_mode = 0;
    wait_idle();
    do_reset();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_req_ctrl.md
# alu_req_ctrl

Sequencing and arbitration controller for the shared 64-bit ALU datapath. Two requesters submit (opcode, A, B) transactions over valid/ready handshakes. A round-robin arbiter grants one transaction at a time. The block decodes the opcode into the ALU's `sel`/`Cin` controls, drives the operands for one cycle, and captures result, carry-out and `{N,O,Z,C}` status into a response register held under backpressure.

## Interface
Parameters:
- `WIDTH`, 64, operand/result width; must match the ALU.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0_valid` / `req1_valid`  in  1  requester i has a transaction.
- `req0_ready` / `req1_ready`  out  1  requester i's transaction is accepted this cycle.
- `req0_op` / `req1_op`  in  3  opcode.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  WIDTH  operands.
- `alu_a`, `alu_b`  out  WIDTH  registered operands to the ALU.
- `alu_sel`  out  5  ALU select: bit0 invert A, bit1 invert B, bits[4:2] result mux.
- `alu_cin`  out  1  adder carry-in.
- `alu_out`  in  WIDTH  ALU result.
- `alu_cout`  in  1  ALU carry-out.
- `alu_status`  in  4  ALU flags `{N,O,Z,C}`.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_id`  out  1  index of the requester that issued the transaction.
- `rsp_data`  out  WIDTH  captured result.
- `rsp_cout`  out  1  captured carry-out.
- `rsp_status`  out  4  captured `{N,O,Z,C}`.
- `busy`  out  1  high when the FSM is not in IDLE.

## Operation
- Opcode decode, as `op` → `alu_sel`, `alu_cin`:
  - ADD 0 → 10000, 0
  - SUB 1 → 10010, 1
  - AND 2 → 01000, 0
  - OR 3 → 00100, 0
  - XOR 4 → 01100, 0
  - SHR 5 → 10100, 0
  - SHL 6 → 11000, 0
  - NOR 7 → 01011, 0 (`~A & ~B`)
- FSM states IDLE, EXEC, RESP.
  - IDLE: when any `reqN_valid` is high, grant one requester, assert its `reqN_ready` combinationally, and register op/A/B/id. Next state is EXEC.
  - EXEC: `alu_*` outputs carry the granted transaction for exactly this cycle. At the end of the cycle, capture `alu_out`/`alu_cout`/`alu_status` into `rsp_*`. Next state is RESP.
  - RESP: `rsp_valid` is high and `rsp_*` is stable until `rsp_ready`. On `rsp_valid & rsp_ready` the next state is IDLE.
- Arbitration is round-robin with a 1-bit priority pointer.
  - The pointer selects the preferred requester. If only one requester is valid, it wins.
  - After each grant, the pointer moves to the non-granted requester.
- `reqN_ready` is low outside IDLE. At most one `reqN_ready` is high in any cycle.
- Requesters hold op/A/B stable while valid and not yet accepted.
- `rsp_id` is the granted index; `rsp_status` is bit-identical to the ALU's status for that operation.
- Outside EXEC:
  - `alu_sel` = 00000, `alu_cin` = 0.
  - `alu_a`/`alu_b` hold their last values; the ALU result is ignored.

## Timing
- Request accepted in cycle T → `alu_*` driven in T+1 → `rsp_valid` high in T+2.
- Return to IDLE in the cycle after the response handshake; next grant is possible in that IDLE cycle.
- Peak throughput is one transaction per 3 cycles.
- Reset values:
  - State IDLE, pointer 0 (requester 0 preferred).
  - `reqN_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rsp_cout`=0, `rsp_status`=0.
  - `alu_a`=`alu_b`=0, `alu_sel`=0, `alu_cin`=0, `busy`=0.
- Boundary conditions:
  - Both requesters valid in the same cycle: the pointer decides; the loser is granted next.
  - `rsp_ready` held low: stays in RESP indefinitely and `rsp_*` must not change.
  - `rsp_ready` high already on the first RESP cycle: one-cycle response.
  - Reset asserted mid-operation (EXEC or RESP): the in-flight transaction is dropped and all outputs return to reset values immediately.
  - A requester deasserting valid before acceptance is legal; nothing is granted to it.

## Structure
- Package `alu_ctrl_pkg`:
  - Opcode enum (ADD…NOR).
  - The 5-bit sel constants (`SEL_OR`=001, `SEL_AND`=010, `SEL_XOR`=011, `SEL_ADD`=100, `SEL_SHR`=101, `SEL_SHL`=110, placed in bits [4:2]).
  - FSM state enum.
  - Status bit indices: C=0, Z=1, O=2, N=3.
- Sub-module `rr_arbiter2`: inputs are two request bits, the pointer and an advance strobe; outputs are a one-hot grant and the updated pointer.
- The decode is a pure function in the package.

## Test plan
- Reset then idle:
  - Stimulus: release `rst` with both requesters idle.
  - Required response: all outputs at reset values; `busy`=0 for 10 cycles.
- SUB:
  - Stimulus: req0, op=SUB, A=5, B=3.
  - Required response at T+1: `alu_sel`=10010, `alu_cin`=1.
  - Required response at T+2: `rsp_valid`=1, `rsp_id`=0, `rsp_data` = ALU output.
  - With the bench ALU model returning 2: `rsp_status` Z=0, N=0.
- Contention:
  - Stimulus: both valid every cycle with ADD; req0 A=1, req1 A=2; `rsp_ready`=1.
  - Required response: `rsp_id` sequence 0,1,0,1; no starvation.
- Backpressure:
  - Stimulus: `rsp_ready`=0 for 20 cycles during RESP.
  - Required response: `rsp_data`/`rsp_status` constant; both `reqN_ready`=0; one response on release.
- Reset mid-op:
  - Stimulus: assert `rst` during EXEC.
  - Required response: `rsp_valid` never rises for that transaction; next request after release is granted to requester 0.
- Decode sweep:
  - Stimulus: all 8 opcodes with A=0xF0F0…, B=4.
  - Required response: `alu_sel` matches the decode list for each opcode; `rsp_data` equals the expected OR/AND/XOR/ADD/SUB/SHR/SHL/NOR result against the reference ALU.
